// File: rtl/disp_arbiter.sv
// Round-robin arbiter sharing the four-digit seven-segment display among four clients.
// Optional blank gap between owners is enabled with the macro DISP_ARB_BLANK_EN.
module disp_arbiter #(
    parameter int DWELL     = 50_000_000,
    parameter int BLANK_CYC = 2_500_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] pat0,
    input  logic [31:0] pat1,
    input  logic [31:0] pat2,
    input  logic [31:0] pat3,
    output logic [3:0]  gnt,
    output logic [7:0]  in3,
    output logic [7:0]  in2,
    output logic [7:0]  in1,
    output logic [7:0]  in0,
    output logic        busy
);

    localparam int DW = $clog2(DWELL + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN   = 2'd1
`ifdef DISP_ARB_BLANK_EN
        ,S_BLANK = 2'd2
`endif
    } state_t;

    state_t      r_state, w_state_next;
    logic [1:0]  r_owner, w_owner_next;
    logic [1:0]  r_ptr, w_ptr_next;
    logic [DW-1:0] r_dwell;
    logic [3:0]  r_gnt;
    logic [31:0] r_disp;
    logic        w_grant_new;

    logic [31:0] w_pat [4];
    logic [3:0]  w_others;
    logic [2:0]  w_pick_all;
    logic [2:0]  w_pick_oth;
    logic        w_dwell_done;

    assign w_pat[0] = pat0;
    assign w_pat[1] = pat1;
    assign w_pat[2] = pat2;
    assign w_pat[3] = pat3;

    // Requests from everyone but the current owner, used for handoff.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_others
            assign w_others[gi] = req[gi] & (r_owner != 2'(gi));
        end
    endgenerate

    // Returns {found, index} of the first set bit at or after start (mod 4).
    function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
        logic [1:0] idx;
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (mask[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign w_pick_all = rr_pick(req, r_ptr);
    assign w_pick_oth = rr_pick(w_others, r_ptr);

    // The grant cycle itself counts as the first dwell cycle.
    assign w_dwell_done = (r_dwell >= DW'(DWELL - 1));

`ifdef DISP_ARB_BLANK_EN
    localparam int BW = $clog2(BLANK_CYC + 1);
    logic [BW-1:0] r_blank;
    logic          w_blank_done;
    assign w_blank_done = (r_blank >= BW'(BLANK_CYC - 1));
`else
    logic w_unused_blank;
    assign w_unused_blank = (BLANK_CYC > 0);
`endif

    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_ptr_next   = r_ptr;
        w_grant_new  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_all[2]) begin
                    w_state_next = S_OWN;
                    w_owner_next = w_pick_all[1:0];
                    w_grant_new  = 1'b1;
                end
            end
            S_OWN: begin
                if ((!req[r_owner] || w_dwell_done) && w_pick_oth[2]) begin
`ifdef DISP_ARB_BLANK_EN
                    w_state_next = S_BLANK;
`else
                    w_owner_next = w_pick_oth[1:0];
                    w_grant_new  = 1'b1;
`endif
                end else if (!req[r_owner]) begin
                    w_state_next = S_IDLE;
                end
            end
`ifdef DISP_ARB_BLANK_EN
            S_BLANK: begin
                if (w_blank_done) begin
                    if (w_pick_all[2]) begin
                        w_state_next = S_OWN;
                        w_owner_next = w_pick_all[1:0];
                        w_grant_new  = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
        if (w_grant_new) w_ptr_next = w_owner_next + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_owner <= 2'd0;
            r_ptr   <= 2'd0;
            r_dwell <= '0;
            r_gnt   <= 4'b0000;
            r_disp  <= 32'hFFFF_FFFF;
        end else begin
            r_state <= w_state_next;
            r_owner <= w_owner_next;
            r_ptr   <= w_ptr_next;
            if (w_grant_new)
                r_dwell <= '0;
            else if (r_state == S_OWN && r_dwell != DW'(DWELL))
                r_dwell <= r_dwell + 1'b1;
            if (w_state_next == S_OWN) begin
                r_gnt  <= 4'b0001 << w_owner_next;
                r_disp <= w_pat[w_owner_next];
            end else begin
                r_gnt  <= 4'b0000;
                r_disp <= 32'hFFFF_FFFF;
            end
        end
    end

`ifdef DISP_ARB_BLANK_EN
    always_ff @(posedge clk) begin
        if (reset)
            r_blank <= '0;
        else if (r_state == S_BLANK)
            r_blank <= r_blank + 1'b1;
        else
            r_blank <= '0;
    end
`endif

    assign gnt  = r_gnt;
    assign busy = |r_gnt;
    assign in3  = r_disp[31:24];
    assign in2  = r_disp[23:16];
    assign in1  = r_disp[15:8];
    assign in0  = r_disp[7:0];

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed self-checking bench for disp_arbiter with DWELL=4, BLANK_CYC=2.
module tb_disp_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] pat0, pat1, pat2, pat3;
    logic [3:0]  gnt;
    logic [7:0]  in3, in2, in1, in0;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    disp_arbiter #(.DWELL(4), .BLANK_CYC(2)) dut (
        .clk(clk), .reset(reset), .req(req),
        .pat0(pat0), .pat1(pat1), .pat2(pat2), .pat3(pat3),
        .gnt(gnt), .in3(in3), .in2(in2), .in1(in1), .in0(in0), .busy(busy)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b1111;
        tick();
        tick();
        n_vec++;
        if (gnt !== 4'b0000) begin $display("FAIL reset_gnt got=%b want=0000", gnt); n_err++; end
        n_vec++;
        if ({in3, in2, in1, in0} !== 32'hFFFFFFFF) begin
            $display("FAIL reset_disp got=%h want=ffffffff", {in3, in2, in1, in0}); n_err++;
        end
        n_vec++;
        if (busy !== 1'b0) begin $display("FAIL reset_busy got=%b want=0", busy); n_err++; end
        reset = 1'b0;
        tick();
        n_vec++;
        if (gnt !== 4'b0001) begin $display("FAIL reset_release_gnt got=%b want=0001", gnt); n_err++; end
        n_vec++;
        if ({in3, in2, in1, in0} !== 32'hA0A1A2A3) begin
            $display("FAIL reset_release_disp got=%h want=a0a1a2a3", {in3, in2, in1, in0}); n_err++;
        end
        $display("reset: gnt=%b busy=%b", gnt, busy);
        req = 4'b0000;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        pat2 = 32'hC0F9A4B0;
        req  = 4'b0100;
        tick();
        n_vec++;
        if (gnt !== 4'b0100 || busy !== 1'b1) begin
            $display("FAIL single_gnt got=%b busy=%b want=0100 busy=1", gnt, busy); n_err++;
        end
        n_vec++;
        if (in3 !== 8'hC0 || in2 !== 8'hF9 || in1 !== 8'hA4 || in0 !== 8'hB0) begin
            $display("FAIL single_disp got=%h want=c0f9a4b0", {in3, in2, in1, in0}); n_err++;
        end
        pat2 = 32'h12345678;
        #1;
        n_vec++;
        if ({in3, in2, in1, in0} !== 32'hC0F9A4B0) begin
            $display("FAIL single_pat_early got=%h want=c0f9a4b0", {in3, in2, in1, in0}); n_err++;
        end
        tick();
        n_vec++;
        if ({in3, in2, in1, in0} !== 32'h12345678) begin
            $display("FAIL single_pat_update got=%h want=12345678", {in3, in2, in1, in0}); n_err++;
        end
        req = 4'b0000;
        tick();
        n_vec++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || {in3, in2, in1, in0} !== 32'hFFFFFFFF) begin
            $display("FAIL single_release got gnt=%b busy=%b disp=%h want 0000/0/ffffffff",
                     gnt, busy, {in3, in2, in1, in0}); n_err++;
        end
        $display("single: owner 2 granted, updated, released");
    endtask

    task automatic test_preempt();
        do_reset();
        req = 4'b0001;
        tick();
        n_vec++;
        if (gnt !== 4'b0001) begin $display("FAIL preempt_grant got=%b want=0001", gnt); n_err++; end
        req = 4'b1001;
        for (int c = 2; c <= 4; c++) begin
            tick();
            n_vec++;
            if (gnt !== 4'b0001) begin
                $display("FAIL preempt_hold cycle=%0d got=%b want=0001", c, gnt); n_err++;
            end
        end
        tick();
        n_vec++;
        if (gnt !== 4'b1000 || {in3, in2, in1, in0} !== 32'hD0D1D2D3) begin
            $display("FAIL preempt_handoff got gnt=%b disp=%h want 1000/d0d1d2d3",
                     gnt, {in3, in2, in1, in0}); n_err++;
        end
        $display("preempt: gnt=%b after 4 dwell cycles", gnt);
        req = 4'b0000;
        tick();
    endtask

    task automatic test_fairness();
        logic [3:0] exp_g;
        do_reset();
        pat2 = 32'hC2C2C2C2;
        req  = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            tick();
            exp_g = 4'b0001 << ((k / 4) % 4);
            n_vec++;
            if (gnt !== exp_g) begin
                $display("FAIL fair_gnt cycle=%0d got=%b want=%b", k, gnt, exp_g); n_err++;
            end
        end
        $display("fairness: 20 cycles checked, final gnt=%b", gnt);
        req = 4'b0000;
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 4'b0011;
        tick();
        n_vec++;
        if (gnt !== 4'b0001) begin $display("FAIL b2b_first got=%b want=0001", gnt); n_err++; end
        req = 4'b0010;
        tick();
        n_vec++;
        if (gnt !== 4'b0010 || {in3, in2, in1, in0} !== 32'hB0B1B2B3) begin
            $display("FAIL b2b_handoff got gnt=%b disp=%h want 0010/b0b1b2b3",
                     gnt, {in3, in2, in1, in0}); n_err++;
        end
        $display("back_to_back: release handoff gnt=%b", gnt);
        req = 4'b0000;
        tick();
    endtask

    task automatic test_blank();
        do_reset();
        req = 4'b0010;
        tick();
        n_vec++;
        if (gnt !== 4'b0010) begin $display("FAIL blank_grant got=%b want=0010", gnt); n_err++; end
        req = 4'b0100;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_vec++;
            if (gnt !== 4'b0000 || busy !== 1'b0 || {in3, in2, in1, in0} !== 32'hFFFFFFFF) begin
                $display("FAIL blank_gap cycle=%0d got gnt=%b busy=%b disp=%h", c, gnt, busy,
                         {in3, in2, in1, in0}); n_err++;
            end
        end
        tick();
        n_vec++;
        if (gnt !== 4'b0100) begin $display("FAIL blank_exit got=%b want=0100", gnt); n_err++; end
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        tick();
        n_vec++;
        if (gnt !== 4'b0000) begin $display("FAIL blank_to_idle got=%b want=0000", gnt); n_err++; end
        req = 4'b0001;
        tick();
        n_vec++;
        if (gnt !== 4'b0001) begin $display("FAIL blank_idle_regrant got=%b want=0001", gnt); n_err++; end
        $display("blank: gap, exit and idle fallback checked");
        req = 4'b0000;
        tick();
    endtask

    task automatic test_midreset();
        do_reset();
        req = 4'b0100;
        tick();
        n_vec++;
        if (gnt !== 4'b0100) begin $display("FAIL midreset_grant got=%b want=0100", gnt); n_err++; end
        reset = 1'b1;
        tick();
        n_vec++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || {in3, in2, in1, in0} !== 32'hFFFFFFFF) begin
            $display("FAIL midreset_clear got gnt=%b busy=%b disp=%h", gnt, busy,
                     {in3, in2, in1, in0}); n_err++;
        end
        reset = 1'b0;
        req   = 4'b1100;
        tick();
        n_vec++;
        if (gnt !== 4'b0100) begin $display("FAIL midreset_regrant got=%b want=0100", gnt); n_err++; end
        $display("midreset: regrant gnt=%b", gnt);
        req = 4'b0000;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        pat0  = 32'hA0A1A2A3;
        pat1  = 32'hB0B1B2B3;
        pat2  = 32'hC0C1C2C3;
        pat3  = 32'hD0D1D2D3;
        test_reset();
        test_single();
`ifdef DISP_ARB_BLANK_EN
        test_blank();
`else
        test_preempt();
        test_fairness();
        test_back_to_back();
`endif
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/disp_arbiter.md
# disp_arbiter

Time-shares the four-digit seven-segment display among four requesters. Each requester presents a 32-bit segment pattern (four 8-bit digit codes) and holds a request line. The arbiter grants ownership round-robin with a minimum dwell time and drives the registered digit codes into the display multiplexer's `in3`..`in0` inputs. It sits between the application clients (counter, status, message, debug) and the display multiplexer.

## Interface
- `DWELL`, 50_000_000: minimum cycles an owner keeps the display before it can be preempted (1 s at 50 MHz); must be ≥1.
- `BLANK_CYC`, 2_500_000: blank-gap length in cycles between owners; used only with `DISP_ARB_BLANK_EN`; must be ≥1.
- `clk`, input, 1: system clock.
- `reset`, input, 1: reset; one clock; reset is synchronous and active-high.
- `req`, input, 4: `req[i]` high means requester i wants the display.
- `pat0`..`pat3`, input, 32 each: requester i pattern; [31:24]=digit3, [23:16]=digit2, [15:8]=digit1, [7:0]=digit0; segments active-low.
- `gnt`, output, 4: registered one-hot grant, or all-zero.
- `in3`,`in2`,`in1`,`in0`, output, 8 each: registered digit codes to the display mux.
- `busy`, output, 1: high when `gnt` is non-zero.

## Operation
- States: IDLE, OWN, and BLANK (BLANK exists only with the macro).
- Registers: `owner` (2 bits), `ptr` (2-bit round-robin pointer), dwell counter. The dwell counter is wide enough to hold `DWELL`, saturates at `DWELL`, and clears on every new grant. With the macro there is also a blank counter.
- Round-robin selection: scan `ptr`, `ptr+1`, … (mod 4) and take the first asserted `req`. On a grant to k, `ptr` becomes k+1 mod 4.
- IDLE:
  - `gnt`=0; outputs 8'hFF (all segments off).
  - Any `req` high → select winner k, go to OWN.
- OWN:
  - Each cycle, `in3..in0` load `pat[owner]` fields.
  - If `req[owner]`=0 (release): any other request pending → hand off; none → IDLE.
  - Else if dwell counter = `DWELL` and another `req` is high → preempt (hand off).
  - Else stay in OWN.
- Handoff selection uses round-robin over the currently asserted requests; the releasing owner is excluded.
- `gnt` never has more than one bit set. Without the macro, handoff moves the grant bit from the old owner to the new one on a single edge.
- Reset at any time: next edge forces IDLE; `gnt`=0, `in*`=8'hFF, `busy`=0, `ptr`=0, counters 0.

## Timing
- `req` sampled at edge t → `gnt` one-hot and first pattern on `in*` valid after edge t+1 (1-cycle latency).
- Pattern changes on the owner's `pat` appear on `in*` one cycle later.
- Release: `req[owner]` low at edge t → `gnt[owner]` low after t+1.
- Preemption occurs no earlier than `DWELL` cycles after the grant edge.
- Simultaneous requests: the first requester at or after `ptr` wins. After reset, requester 0 has highest priority.
- Owner dropping and re-raising `req` within one cycle still releases; re-acquisition goes through normal arbitration.

## Configuration
- Macro: `DISP_ARB_BLANK_EN`.
- Defined:
  - Every handoff (release-with-pending or preempt) enters BLANK for `BLANK_CYC` cycles with `gnt`=0, `busy`=0, `in*`=8'hFF.
  - At BLANK exit, re-arbitrate on the current `req` from `ptr`; if no request is pending, go to IDLE.
  - IDLE→OWN has no blank.
  - Reset during BLANK → IDLE.
- Undefined: BLANK state and counter absent; handoff is direct OWN→OWN.

## Test plan
- Bench parameters: `DWELL`=4, `BLANK_CYC`=2.
- Reset: assert `reset` 2 cycles with `req`=4'b1111 → `gnt`=0, `in*`=8'hFF, `busy`=0; release → `gnt`=4'b0001 one cycle later.
- Single owner: `req`=4'b0100, `pat2`=32'hC0F9A4B0 → next cycle `gnt`=4'b0100, `in3`=C0, `in2`=F9, `in1`=A4, `in0`=B0. Change `pat2` → `in*` updates one cycle later; drop `req` → `gnt`=0, `in*`=FF.
- Preemption: requester 0 holds, requester 3 raises at grant+1 → `gnt` stays 4'b0001 for exactly 4 cycles, then 4'b1000 (no macro).
- Fairness: `req`=4'b1111 held continuously → grant sequence 0,1,2,3,0, each granted 4 cycles.
- Blank (macro on): owner 1 drops `req` with `req[2]` high → 2 cycles of `gnt`=0 and `in*`=FF, then `gnt`=4'b0100. Drop `req[2]` during the blank → IDLE instead.
- Mid-operation reset: `reset` pulsed while owner 2 is granted → next cycle `gnt`=0; after release, simultaneous `req`=4'b1100 → `gnt`=4'b0100.
